// File: rtl/carrier_pattern_decoder.sv
// carrier_pattern_decoder
//   Receive-side decoder for the 8-line carrier pattern link. Each line carries
//   a toggling carrier for a '1' and a held-low level for a '0'. Rising carrier
//   edges are counted per line over a fixed window. At the end of each window
//   every line is decided against a threshold. The decoded byte is then
//   debounced over consecutive windows before it is presented downstream.
//
//   Parameters
//     WINDOW_CYCLES  clk cycles per decision window (>= 16)
//     MIN_EDGES      rising edges per window needed to decode a '1' (>= 1)
//     DEBOUNCE       consecutive identical decodes before pattern_out moves (>= 1)
//     EDGE_W         per-line edge counter width (saturating)
//
//   Ports
//     clk             system clock, rising edge
//     rst_n           asynchronous active-low reset
//     carrier_in[7:0] carrier lines, asynchronous to clk
//     pattern_raw     per-window undebounced decode
//     window_valid    1-cycle pulse, pattern_raw is new this cycle
//     pattern_out     debounced decoded pattern
//     pattern_changed 1-cycle pulse, pattern_out took a new value this cycle

// Per-line front end: synchronizer, rising-edge detect, saturating edge count
// and the threshold decision for the window that is closing.
module carrier_pattern_decoder_lane #(
  parameter int MIN_EDGES = 4,
  parameter int EDGE_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic carrier_i,
  input  logic win_end_i,
  output logic raw_o
);

  localparam logic [EDGE_W-1:0] CNT_MAX = '1;

  logic              sync1_q, sync2_q, prev_q;
  logic              rise;
  logic [EDGE_W-1:0] cnt_q, cnt_d;
  logic [31:0]       total;

  assign rise = sync2_q & ~prev_q;

  // An edge seen in the window-end cycle still belongs to the closing window,
  // so it is added in here rather than waiting for the counter.
  assign total = 32'(cnt_q) + 32'(rise);
  assign raw_o = (total >= 32'(MIN_EDGES));

  always_comb begin
    cnt_d = cnt_q;
    if (win_end_i)                     cnt_d = '0;
    else if (rise && cnt_q != CNT_MAX) cnt_d = cnt_q + EDGE_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= carrier_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end

endmodule

module carrier_pattern_decoder #(
  parameter int WINDOW_CYCLES = 1024,
  parameter int MIN_EDGES     = 4,
  parameter int DEBOUNCE      = 2,
  parameter int EDGE_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] carrier_in,
  output logic [7:0] pattern_raw,
  output logic       window_valid,
  output logic [7:0] pattern_out,
  output logic       pattern_changed
);

  localparam int NUM_LANES = 8;
  localparam int WIN_W     = $clog2(WINDOW_CYCLES);
  localparam int MATCH_W   = $clog2(DEBOUNCE + 1);
  localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [MATCH_W-1:0] DEB_MAX  = MATCH_W'(DEBOUNCE);

  logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
  logic                 win_end;
  logic [NUM_LANES-1:0] raw_w;

  logic [NUM_LANES-1:0] raw_q, raw_d;
  logic                 valid_q, valid_d;
  logic [NUM_LANES-1:0] cand_q, cand_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [NUM_LANES-1:0] out_q, out_d;
  logic                 chg_q, chg_d;

  // ---------------------------------------------------------------- window
  assign win_end   = (win_cnt_q == WIN_LAST);
  assign win_cnt_d = win_end ? '0 : win_cnt_q + WIN_W'(1);

  // ----------------------------------------------------------------- lanes
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    carrier_pattern_decoder_lane #(
      .MIN_EDGES (MIN_EDGES),
      .EDGE_W    (EDGE_W)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .carrier_i (carrier_in[g]),
      .win_end_i (win_end),
      .raw_o     (raw_w[g])
    );
  end

  // -------------------------------------------------------------- debounce
  // cand holds the most recent window decode and match counts how many
  // consecutive windows agreed with it (capped at DEBOUNCE). The output moves
  // only once the candidate has been seen DEBOUNCE times in a row.
  always_comb begin
    raw_d   = raw_q;
    valid_d = win_end;
    cand_d  = cand_q;
    match_d = match_q;
    out_d   = out_q;
    chg_d   = 1'b0;
    if (win_end) begin
      raw_d = raw_w;
      if (raw_w == cand_q) begin
        if (match_q < DEB_MAX) match_d = match_q + MATCH_W'(1);
      end else begin
        cand_d  = raw_w;
        match_d = MATCH_W'(1);
      end
      if (match_d >= DEB_MAX && cand_d != out_q) begin
        out_d = cand_d;
        chg_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q <= '0;
      raw_q     <= '0;
      valid_q   <= 1'b0;
      cand_q    <= '0;
      match_q   <= '0;
      out_q     <= '0;
      chg_q     <= 1'b0;
    end else begin
      win_cnt_q <= win_cnt_d;
      raw_q     <= raw_d;
      valid_q   <= valid_d;
      cand_q    <= cand_d;
      match_q   <= match_d;
      out_q     <= out_d;
      chg_q     <= chg_d;
    end
  end

  assign pattern_raw     = raw_q;
  assign window_valid    = valid_q;
  assign pattern_out     = out_q;
  assign pattern_changed = chg_q;

endmodule

// File: tb/tb_carrier_pattern_decoder.sv
module tb_carrier_pattern_decoder;

  localparam int W    = 64;
  localparam int MINE = 4;
  localparam int DEB  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] carrier_in = 8'h00;
  logic [7:0] pattern_raw, pattern_out, s_raw, s_out;
  logic       window_valid, pattern_changed, s_valid, s_chg;

  int checks = 0;
  int failures = 0;
  int ph = 0;
  int chg_seen = 0;

  always #5 clk = ~clk;

  carrier_pattern_decoder #(.WINDOW_CYCLES(W), .MIN_EDGES(MINE), .DEBOUNCE(DEB), .EDGE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .carrier_in(carrier_in),
    .pattern_raw(pattern_raw), .window_valid(window_valid),
    .pattern_out(pattern_out), .pattern_changed(pattern_changed));

  // Narrow counters: 8 edges per window saturate at 7 and must still decode 1.
  carrier_pattern_decoder #(.WINDOW_CYCLES(W), .MIN_EDGES(MINE), .DEBOUNCE(DEB), .EDGE_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .carrier_in(carrier_in),
    .pattern_raw(s_raw), .window_valid(s_valid),
    .pattern_out(s_out), .pattern_changed(s_chg));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------ reference model
  // samp holds the last four values of carrier_in seen at clock edges since
  // reset release. A line rising between two samples is counted two edges
  // later (synchronizer latency), in whichever window that edge closes.
  logic [7:0] samp[$];
  int         cnt[8];
  logic [7:0] rhist[$];
  int         n;
  logic [7:0] m_raw, m_out;
  logic       m_valid, m_chg;

  task automatic model_reset();
    samp = {8'h00, 8'h00, 8'h00, 8'h00};
    foreach (cnt[i]) cnt[i] = 0;
    rhist.delete();
    n = 0;
    m_raw = 8'h00; m_out = 8'h00; m_valid = 1'b0; m_chg = 1'b0;
  endtask

  task automatic model_step();
    logic [7:0] rise;
    bit         same;
    n++;
    samp.push_back(carrier_in);
    if (samp.size() > 4) void'(samp.pop_front());
    rise = samp[1] & ~samp[0];
    for (int i = 0; i < 8; i++) if (rise[i]) cnt[i]++;
    m_valid = 1'b0;
    m_chg   = 1'b0;
    if (n % W == 0) begin
      m_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
        m_raw[i] = (cnt[i] >= MINE);
        cnt[i] = 0;
      end
      rhist.push_back(m_raw);
      if (rhist.size() > DEB) void'(rhist.pop_front());
      same = (rhist.size() == DEB);
      foreach (rhist[k]) if (rhist[k] != m_raw) same = 1'b0;
      if (same && m_raw != m_out) begin
        m_out = m_raw;
        m_chg = 1'b1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Continuous scoreboard, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("sb_valid",  window_valid,    m_valid);
      chk("sb_raw",    pattern_raw,     m_raw);
      chk("sb_out",    pattern_out,     m_out);
      chk("sb_chg",    pattern_changed, m_chg);
      chk("sb_satraw", s_raw,           m_raw);
      chk("sb_satout", s_out,           m_out);
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic cycle(input logic [7:0] on, input logic [7:0] hi);
    @(posedge clk);
    #1;
    carrier_in = (ph[2] ? on : 8'h00) | hi;
    ph++;
    if (pattern_changed) chg_seen++;
  endtask

  task automatic run_windows(input logic [7:0] on, input logic [7:0] hi, input int nwin);
    repeat (nwin * W) cycle(on, hi);
  endtask

  task automatic wait_valid(input logic [7:0] on, input logic [7:0] hi, output int k);
    k = 0;
    do begin
      cycle(on, hi);
      k++;
    end while (!window_valid && k < 200);
  endtask

  task automatic drive_window(input logic [63:0] wave);
    for (int c = 0; c < 64; c++) begin
      @(posedge clk);
      #1;
      carrier_in = {7'b0, wave[c]};
    end
  endtask

  function automatic logic [63:0] mkw(input int a, input int b, input int c, input int d);
    logic [63:0] w;
    w = '0;
    w[a] = 1'b1; w[a+1] = 1'b1;
    w[b] = 1'b1; w[b+1] = 1'b1;
    w[c] = 1'b1; w[c+1] = 1'b1;
    if (d >= 0) for (int i = d; i < 64; i++) w[i] = 1'b1;
    return w;
  endfunction

  typedef struct {
    logic [7:0] on;
    logic [7:0] hi;
    int         nwin;
    logic [7:0] exp_raw;
    logic [7:0] exp_out;
    int         exp_chg;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int k;
    logic [7:0] on, hi;
    int rate[8];

    tbl[0]  = '{8'hA5, 8'h00, 2, 8'hA5, 8'hA5, 1};
    tbl[1]  = '{8'hA5, 8'h00, 2, 8'hA5, 8'hA5, 0};
    tbl[2]  = '{8'h3C, 8'h00, 3, 8'h3C, 8'h3C, 1};
    tbl[3]  = '{8'hFF, 8'h00, 1, 8'hFF, 8'h3C, 0};
    tbl[4]  = '{8'h3C, 8'h00, 3, 8'h3C, 8'h3C, 0};
    tbl[5]  = '{8'h01, 8'h80, 2, 8'h01, 8'h01, 1};
    tbl[6]  = '{8'h00, 8'hFF, 2, 8'h00, 8'h00, 1};
    tbl[7]  = '{8'h00, 8'h00, 2, 8'h00, 8'h00, 0};
    tbl[8]  = '{8'hFF, 8'h00, 2, 8'hFF, 8'hFF, 1};
    tbl[9]  = '{8'h5A, 8'h00, 1, 8'h5A, 8'hFF, 0};
    tbl[10] = '{8'hA5, 8'h00, 1, 8'hA5, 8'hFF, 0};
    tbl[11] = '{8'hA5, 8'h00, 1, 8'hA5, 8'hA5, 1};

    // Reset with arbitrary carrier activity.
    carrier_in = 8'($urandom);
    #2 rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 carrier_in = 8'($urandom);
    end
    @(negedge clk);
    chk("rst_raw",   pattern_raw,     8'h00);
    chk("rst_out",   pattern_out,     8'h00);
    chk("rst_valid", window_valid,    1'b0);
    chk("rst_chg",   pattern_changed, 1'b0);

    @(posedge clk);
    #1;
    carrier_in = 8'h00;
    rst_n = 1'b1;
    wait_valid(8'hA5, 8'h00, k);
    chk("first_valid_latency", k, W);
    chk("w1_raw", pattern_raw, 8'hA5);
    chk("w1_out", pattern_out, 8'h00);

    // Steady / glitch / static-high vectors.
    foreach (tbl[r]) begin
      chg_seen = 0;
      run_windows(tbl[r].on, tbl[r].hi, tbl[r].nwin);
      chk($sformatf("vec%0d_raw", r), pattern_raw, tbl[r].exp_raw);
      chk($sformatf("vec%0d_out", r), pattern_out, tbl[r].exp_out);
      chk($sformatf("vec%0d_chg", r), chg_seen,    tbl[r].exp_chg);
    end

    // Reset in the middle of a window.
    repeat (30) cycle(8'hFF, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out",   pattern_out,  8'h00);
    chk("midrst_raw",   pattern_raw,  8'h00);
    chk("midrst_valid", window_valid, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_valid(8'hFF, 8'h00, k);
    chk("midrst_valid_latency", k, W);
    chk("midrst_w1_out", pattern_out, 8'h00);
    run_windows(8'hFF, 8'h00, 1);
    chk("midrst_w2_out", pattern_out, 8'hFF);

    // Threshold boundary on channel 0, with edges at the window end.
    drive_window(64'h0);
    chk("thr_quiet", pattern_raw[0], 1'b0);
    drive_window(mkw(10, 20, 30, -1));
    chk("thr_3edges", pattern_raw[0], 1'b0);
    drive_window(mkw(10, 20, 30, 60));
    chk("thr_4th_at_end", pattern_raw[0], 1'b1);
    drive_window(mkw(10, 20, 30, 61));
    chk("thr_4th_late", pattern_raw[0], 1'b0);
    drive_window(mkw(10, 20, 30, -1));
    chk("thr_spill_counts", pattern_raw[0], 1'b1);
    drive_window(64'h0);
    chk("thr_idle", pattern_raw[0], 1'b0);

    // Randomized traffic, checked by the scoreboard.
    for (int w = 0; w < 24; w++) begin
      if ($urandom_range(0, 1) == 1) begin
        on = 8'($urandom);
        hi = 8'($urandom) & 8'($urandom);
        run_windows(on, hi, $urandom_range(1, 3));
      end else begin
        foreach (rate[i]) rate[i] = (2 << $urandom_range(0, 3)) - 1;
        for (int c = 0; c < W; c++) begin
          @(posedge clk);
          #1;
          for (int i = 0; i < 8; i++)
            if ($urandom_range(0, rate[i]) == 0) carrier_in[i] = ~carrier_in[i];
        end
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    failures++;
    $display("FAIL watchdog timeout t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
